// File: rtl/wasm_operand_stack.sv
// WebAssembly operand stack: PUSH/POP/DROP/DUP plus a native two-cycle SELECT, with sticky traps.
// Latency: single-cycle ops are visible the cycle after accept; SELECT results appear two cycles after accept.
// Backpressure: op_ready_o drops during the SELECT second cycle and after any trap, and stays low until reset.
module wasm_operand_stack #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             op_valid_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             op_ready_o,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             pop_valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic             result_empty_o,
   output logic [CNT_W-1:0] depth_o,
   output logic [2:0]       trap_o
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] OP_PUSH   = 3'd1;
   localparam logic [2:0] OP_POP    = 3'd2;
   localparam logic [2:0] OP_DROP   = 3'd3;
   localparam logic [2:0] OP_SELECT = 3'd4;
   localparam logic [2:0] OP_DUP    = 3'd5;

   localparam logic [2:0] TRAP_NONE  = 3'd0;
   localparam logic [2:0] TRAP_UNDER = 3'd1;
   localparam logic [2:0] TRAP_OVER  = 3'd2;

   typedef enum logic {S_IDLE, S_SEL2} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] depth_q, depth_d;
   logic [WIDTH-1:0] tos_q, tos_d;
   logic [WIDTH-1:0] val2_q, val2_d;
   logic             cond_q, cond_d;
   logic [2:0]       trap_q, trap_d;
   logic [WIDTH-1:0] pop_data_q, pop_data_d;
   logic             pop_valid_q, pop_valid_d;

   // Entries below the top of stack; entry k lives at mem_q[k].
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [CNT_W-1:0] depth_m1, depth_m2, depth_m3;
   logic [AW-1:0]    rd_idx;
   logic [WIDTH-1:0] rd_dat;
   logic             wr_en;
   logic             accept;

   assign depth_m1 = depth_q - CNT_W'(1);
   assign depth_m2 = depth_q - CNT_W'(2);
   assign depth_m3 = depth_q - CNT_W'(3);

   // The single array read port: SEL2 fetches val1, every other cycle fetches the entry just under TOS.
   assign rd_idx = (state_q == S_SEL2) ? depth_m3[AW-1:0] : depth_m2[AW-1:0];
   assign rd_dat = mem_q[rd_idx];

   assign op_ready_o     = (state_q == S_IDLE) && (trap_q == TRAP_NONE);
   assign accept         = op_valid_i && op_ready_o;
   assign result_o       = (depth_q == '0) ? '0 : tos_q;
   assign result_empty_o = (depth_q == '0);
   assign depth_o        = depth_q;
   assign trap_o         = trap_q;
   assign pop_data_o     = pop_data_q;
   assign pop_valid_o    = pop_valid_q;

   // Next-state logic for the FSM, stack pointer, TOS and trap; a faulting op only updates trap.
   always_comb begin
      state_d     = state_q;
      depth_d     = depth_q;
      tos_d       = tos_q;
      val2_d      = val2_q;
      cond_d      = cond_q;
      trap_d      = trap_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      wr_en       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op_i)
                  OP_PUSH: begin
                     if (depth_q < CNT_W'(DEPTH)) begin
                        tos_d   = push_data_i;
                        depth_d = depth_q + CNT_W'(1);
                        wr_en   = (depth_q != '0);
                     end else begin
                        trap_d = TRAP_OVER;
                     end
                  end
                  OP_POP, OP_DROP: begin
                     if (depth_q != '0) begin
                        // Garbage when popping the last entry, but result_o masks it to zero.
                        tos_d   = rd_dat;
                        depth_d = depth_m1;
                        if (op_i == OP_POP) begin
                           pop_data_d  = tos_q;
                           pop_valid_d = 1'b1;
                        end
                     end else begin
                        trap_d = TRAP_UNDER;
                     end
                  end
                  OP_DUP: begin
                     if (depth_q == '0) begin
                        trap_d = TRAP_UNDER;
                     end else if (depth_q == CNT_W'(DEPTH)) begin
                        trap_d = TRAP_OVER;
                     end else begin
                        depth_d = depth_q + CNT_W'(1);
                        wr_en   = 1'b1;
                     end
                  end
                  OP_SELECT: begin
                     if (depth_q >= CNT_W'(3)) begin
                        // i32 condition: only the low word of TOS counts.
                        cond_d  = (tos_q[31:0] != 32'd0);
                        val2_d  = rd_dat;
                        state_d = S_SEL2;
                     end else begin
                        trap_d = TRAP_UNDER;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_SEL2: begin
            tos_d   = cond_q ? rd_dat : val2_q;
            depth_d = depth_m2;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset that also aborts an in-flight SELECT.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         depth_q     <= '0;
         tos_q       <= '0;
         val2_q      <= '0;
         cond_q      <= 1'b0;
         trap_q      <= TRAP_NONE;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         depth_q     <= depth_d;
         tos_q       <= tos_d;
         val2_q      <= val2_d;
         cond_q      <= cond_d;
         trap_q      <= trap_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
      end
   end

   // Spill the old TOS into the array when PUSH or DUP grows the stack.
   always_ff @(posedge clk_i) begin
      if (wr_en && !reset_i) begin
         mem_q[depth_m1[AW-1:0]] <= tos_q;
      end
   end

endmodule

// File: tb/tb_wasm_operand_stack.sv
// Directed bench for wasm_operand_stack with a queue scoreboard for POP data.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled at the same point.
// Bounded by construction: a fixed linear sequence of steps ending in $finish.
module tb_wasm_operand_stack;

   localparam int W  = 64;
   localparam int D  = 16;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          op_valid;
   logic [2:0]    op;
   logic [W-1:0]  push_data;
   logic          op_ready;
   logic [W-1:0]  pop_data;
   logic          pop_valid;
   logic [W-1:0]  result;
   logic          result_empty;
   logic [CW-1:0] depth;
   logic [2:0]    trap;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q [$];

   wasm_operand_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .op_valid_i     (op_valid),
      .op_i           (op),
      .push_data_i    (push_data),
      .op_ready_o     (op_ready),
      .pop_data_o     (pop_data),
      .pop_valid_o    (pop_valid),
      .result_o       (result),
      .result_empty_o (result_empty),
      .depth_o        (depth),
      .trap_o         (trap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [2:0] o, input logic [63:0] d);
      op_valid  = 1'b1;
      op        = o;
      push_data = d;
      tick();
      op_valid  = 1'b0;
      op        = 3'd0;
   endtask

   task automatic push(input logic [63:0] d);
      do_op(3'd1, d);
   endtask

   task automatic pop_expect(input logic [63:0] d);
      exp_q.push_back(d);
      do_op(3'd2, 64'd0);
      chk("pop_vld", 64'(pop_valid), 64'd1);
      if (pop_valid && exp_q.size() > 0) chk("pop_dat", pop_data, exp_q.pop_front());
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic run_select(input logic [63:0] c, input logic [63:0] exp_res, input string tag);
      push(64'd7);
      push(64'd9);
      push(c);
      do_op(3'd4, 64'd0);
      chk({tag, "_sel2_rdy"}, 64'(op_ready), 64'd0);
      chk({tag, "_sel2_depth"}, 64'(depth), 64'd3);
      tick();
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_depth"}, 64'(depth), 64'd1);
      chk({tag, "_empty"}, 64'(result_empty), 64'd0);
      chk({tag, "_trap"}, 64'(trap), 64'd0);
   endtask

   initial begin
      reset     = 1'b1;
      op_valid  = 1'b0;
      op        = 3'd0;
      push_data = '0;
      tick();
      tick();
      reset = 1'b0;

      chk("rst_depth", 64'(depth), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_empty", 64'(result_empty), 64'd1);
      chk("rst_trap", 64'(trap), 64'd0);
      chk("rst_pop_vld", 64'(pop_valid), 64'd0);
      chk("rst_pop_dat", pop_data, 64'd0);
      chk("rst_rdy", 64'(op_ready), 64'd1);

      // SELECT with true, false and upper-bits-only conditions
      run_select(64'd1, 64'd7, "sel_true");
      do_reset();
      run_select(64'd0, 64'd9, "sel_false");
      do_reset();
      run_select(64'h1_0000_0000, 64'd9, "sel_hi");
      do_reset();

      // LIFO order through DUP and POP
      push(64'd10);
      push(64'd20);
      push(64'd30);
      do_op(3'd5, 64'd0);
      chk("dup_depth", 64'(depth), 64'd4);
      chk("dup_result", result, 64'd30);
      pop_expect(64'd30);
      pop_expect(64'd30);
      do_op(3'd3, 64'd0);
      chk("drop_result", result, 64'd10);
      chk("drop_pop_vld", 64'(pop_valid), 64'd0);
      pop_expect(64'd10);
      chk("lifo_empty", 64'(result_empty), 64'd1);
      chk("lifo_result", result, 64'd0);
      do_reset();

      // Fill, then overflow
      for (int i = 0; i < D; i++) push(64'(i));
      chk("full_depth", 64'(depth), 64'(D));
      chk("full_result", result, 64'(D - 1));
      chk("full_trap", 64'(trap), 64'd0);
      do_op(3'd5, 64'd0);
      chk("dupfull_trap", 64'(trap), 64'd2);
      chk("dupfull_depth", 64'(depth), 64'(D));
      do_reset();
      for (int i = 0; i < D; i++) push(64'(i));
      push(64'd99);
      chk("ovf_trap", 64'(trap), 64'd2);
      chk("ovf_depth", 64'(depth), 64'(D));
      chk("ovf_result", result, 64'(D - 1));
      chk("ovf_rdy", 64'(op_ready), 64'd0);
      do_op(3'd2, 64'd0);
      chk("trapped_pop_ignored", 64'(depth), 64'(D));
      chk("trapped_pop_vld", 64'(pop_valid), 64'd0);
      do_reset();
      chk("ovf_rst_trap", 64'(trap), 64'd0);
      chk("ovf_rst_depth", 64'(depth), 64'd0);
      chk("ovf_rst_empty", 64'(result_empty), 64'd1);

      // Underflow cases
      push(64'd5);
      push(64'd6);
      do_op(3'd4, 64'd0);
      chk("sel_unf_trap", 64'(trap), 64'd1);
      chk("sel_unf_depth", 64'(depth), 64'd2);
      chk("sel_unf_result", result, 64'd6);
      do_reset();
      do_op(3'd2, 64'd0);
      chk("pop_unf_trap", 64'(trap), 64'd1);
      chk("pop_unf_vld", 64'(pop_valid), 64'd0);
      do_reset();
      do_op(3'd5, 64'd0);
      chk("dup_unf_trap", 64'(trap), 64'd1);
      do_reset();

      // POP strobe, held PUSH during SEL2, reset during SEL2
      push(64'd3);
      pop_expect(64'd3);
      chk("pop3_empty", 64'(result_empty), 64'd1);
      tick();
      chk("pop_strobe_len", 64'(pop_valid), 64'd0);
      chk("pop_data_hold", pop_data, 64'd3);

      push(64'd7);
      push(64'd9);
      push(64'd1);
      do_op(3'd4, 64'd0);
      op_valid  = 1'b1;
      op        = 3'd1;
      push_data = 64'd55;
      chk("held_rdy", 64'(op_ready), 64'd0);
      tick();
      op_valid = 1'b0;
      op       = 3'd0;
      chk("held_result", result, 64'd7);
      chk("held_depth", 64'(depth), 64'd1);
      tick();
      chk("held_not_queued", 64'(depth), 64'd1);

      push(64'd1);
      push(64'd2);
      do_op(3'd4, 64'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_sel2_depth", 64'(depth), 64'd0);
      chk("rst_sel2_rdy", 64'(op_ready), 64'd1);
      tick();
      chk("rst_sel2_after", 64'(depth), 64'd0);
      chk("rst_sel2_empty", 64'(result_empty), 64'd1);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
